alt_cal_wsum: RTL and testbench
===============================

// Module: alt_cal_wsum
// PURPOSE
//  Parametrised successor of the fixed 3-term s-calculator: computes S = sum_k (+/-)C_k*N_k, then >>SHIFT.
//  NTERM unsigned count inputs, per-term compile-time coefficient and sign; one shared multiplier, one term/cycle.
//  Optional round-half-up, unsigned saturation to OUT_W, error flags (neg/zero/overflow), abort.
//  Sits between the count-statistics collector and the error-estimate divider stage.
// PARAMETERS
//  NTERM  3  number of terms (1..8)
//  IN_W   25  width of each count input (unsigned)
//  COEF_W 30  width of each coefficient (unsigned)
//  COEFS  {30'd827155766,30'd5592433,30'd483207710}  packed; C_k = COEFS[k*COEF_W +: COEF_W]
//  SUBMASK 3'b110  bit k=1 -> term k subtracted, 0 -> added
//  SHIFT  22  arithmetic right shift (coefficient amplification) applied to final sum
//  ROUND  0  1: add 2^(SHIFT-1) before shift (round half up); 0: truncate (floor)
//  OUT_W  32  output width (unsigned)
// PORTS
//  clk      in   1              clock
//  rst_n    in   1              reset, asynchronous assert, active low
//  i_start  in   1              start pulse; sampled only when o_busy=0
//  i_abort  in   1              synchronous abort of a running calculation
//  i_n      in   NTERM*IN_W     packed counts; term k at [k*IN_W +: IN_W]
//  o_busy   out  1              calculation in progress
//  o_sum    out  OUT_W          result, held until next result
//  o_vld    out  1              one-cycle pulse, o_sum/o_err valid
//  o_err    out  3              {ovf,zero,neg}, held with o_sum
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-low.
//  Reset: o_busy=0, o_sum=0, o_vld=0, o_err=0, FSM=IDLE, acc=0, idx=0.
//  ACC_W = IN_W+COEF_W+$clog2(NTERM)+1, signed; products are unsigned IN_W+COEF_W, zero-extended.
//  FSM IDLE: i_start=1 -> latch i_n into operand reg, acc<=0, idx<=0, o_busy<=1, o_err<=0 -> MAC.
//  FSM MAC: per edge acc <= acc +/- C_idx*N_idx (sign from SUBMASK[idx]); idx++;
//   after idx=NTERM-1 -> FIN. Exactly NTERM MAC edges.
//  FSM FIN (one edge): r = (acc + (ROUND ? 2^(SHIFT-1) : 0)) >>> SHIFT;
//   neg  = acc<0 -> o_sum=0;  zero = acc==0 -> o_sum=0;
//   ovf  = r>=2^OUT_W -> o_sum=2^OUT_W-1; else o_sum=r[OUT_W-1:0];
//   o_vld<=1 for one cycle, o_busy<=0 -> IDLE.
//  Latency: edge sampling i_start = E0; o_vld high after edge E(NTERM+1) (4 edges for defaults).
//  i_start while o_busy=1: ignored, latched operands unaffected. i_start in the o_vld cycle: accepted
//   (busy already 0) -> back-to-back throughput NTERM+2 cycles.
//  i_n changes after E0 have no effect on the running calculation.
//  i_abort in MAC/FIN: -> IDLE next edge, o_busy<=0, no o_vld, o_sum/o_err keep previous values.
//   i_abort in IDLE: no effect; i_abort and i_start same cycle in IDLE: start wins.
//  rst_n low mid-operation: immediate return to reset values, no o_vld.
//  Only one of neg/zero can be set; ovf only with acc>0. ROUND=1 on acc>0 may cause ovf at boundary.
// TESTING
//  Defaults, i_n={0,0,1000} -> after 4 edges o_vld=1, o_sum=115205, o_err=3'b000, o_busy 1 for 4 cycles.
//  ROUND=1, same stimulus -> o_sum=115206 (frac .696 rounds up).
//  i_n={0,1,0} -> acc=-5592433, o_sum=0, o_err=3'b001; i_n all 0 -> o_sum=0, o_err=3'b010.
//  OUT_W=16, i_n={0,0,1000} -> o_sum=65535, o_err=3'b100.
//  Start, change i_n and pulse i_start at E2 -> result equals original operands; start again in o_vld cycle -> second o_vld exactly 5 cycles later.
//  i_abort at E2 -> no o_vld, o_busy=0 at E3, o_sum unchanged; rst_n low at E1 -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/alt_cal_wsum_if.sv
// Handshake/bus bundle for the weighted-sum calculator: start/abort/count
// operands towards the block, busy/result/valid/error flags back out.
interface alt_cal_wsum_if #(
  parameter int unsigned NTERM = 3,
  parameter int unsigned IN_W  = 25,
  parameter int unsigned OUT_W = 32
);
  logic                    i_start;
  logic                    i_abort;
  logic [NTERM*IN_W-1:0]   i_n;
  logic                    o_busy;
  logic [OUT_W-1:0]        o_sum;
  logic                    o_vld;
  logic [2:0]              o_err;

  modport master (
    output i_start, i_abort, i_n,
    input  o_busy, o_sum, o_vld, o_err
  );

  modport slave (
    input  i_start, i_abort, i_n,
    output o_busy, o_sum, o_vld, o_err
  );
endinterface

// File: rtl/alt_cal_wsum.sv
// Weighted-sum calculator: S = sum_k (+/-)C_k*N_k, then >>> SHIFT with
// optional round-half-up, unsigned saturation to OUT_W and {ovf,zero,neg}
// flags. One shared multiplier, one term per clock.
module alt_cal_wsum #(
  parameter int unsigned             NTERM   = 3,
  parameter int unsigned             IN_W    = 25,
  parameter int unsigned             COEF_W  = 30,
  parameter logic [NTERM*COEF_W-1:0] COEFS   = {30'd827155766, 30'd5592433, 30'd483207710},
  parameter logic [NTERM-1:0]        SUBMASK = 3'b110,
  parameter int unsigned             SHIFT   = 22,
  parameter bit                      ROUND   = 1'b0,
  parameter int unsigned             OUT_W   = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alt_cal_wsum_if.slave  bus
);

  localparam int unsigned PROD_W = IN_W + COEF_W;
  localparam int unsigned ACC_W  = IN_W + COEF_W + $clog2(NTERM) + 1;
  localparam int unsigned IDX_W  = (NTERM > 1) ? $clog2(NTERM) : 1;
  localparam int unsigned EXT_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NTERM - 1);
  // Half an output LSB; shifting 2^SHIFT right by one keeps SHIFT=0 legal.
  localparam logic signed [ACC_W-1:0] RND_ADD  = ROUND ? ((ACC_W'(1) << SHIFT) >> 1) : '0;
  localparam logic [EXT_W-1:0]        OVF_LIM  = EXT_W'(1) << OUT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [NTERM*IN_W-1:0]     r_n;
  logic signed [ACC_W-1:0]   r_acc;
  logic [IDX_W-1:0]          r_idx;
  logic [OUT_W-1:0]          r_sum;
  logic                      r_vld;
  logic [2:0]                r_err;

  logic                      w_load;
  logic                      w_mac;
  logic                      w_fin;
  logic [IN_W-1:0]           w_n_sel;
  logic [COEF_W-1:0]         w_c_sel;
  logic                      w_sub;
  logic [PROD_W-1:0]         w_prod;
  logic signed [ACC_W-1:0]   w_term;
  logic signed [ACC_W-1:0]   w_acc_nxt;
  logic signed [ACC_W-1:0]   w_acc_rnd;
  logic signed [ACC_W-1:0]   w_r;
  logic [EXT_W-1:0]          w_r_ext;
  logic                      w_neg;
  logic                      w_zero;
  logic                      w_ovf;
  logic [OUT_W-1:0]          w_sum;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and datapath strobes; abort beats completion, start only in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_mac       = 1'b0;
    w_fin       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_load      = 1'b1;
          w_state_nxt = MAC;
        end
      end
      MAC: begin
        if (bus.i_abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_mac = 1'b1;
          if (r_idx == LAST_IDX) w_state_nxt = FIN;
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
        if (!bus.i_abort) w_fin = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Select the operand, coefficient and sign of the current term.
  always_comb begin
    w_n_sel = '0;
    w_c_sel = '0;
    w_sub   = 1'b0;
    for (int unsigned k = 0; k < NTERM; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_n_sel = r_n[k*IN_W +: IN_W];
        w_c_sel = COEFS[k*COEF_W +: COEF_W];
        w_sub   = SUBMASK[k];
      end
    end
  end

  // Shared multiplier and accumulate/subtract step.
  always_comb begin
    w_prod    = PROD_W'(w_n_sel) * PROD_W'(w_c_sel);
    w_term    = signed'({{(ACC_W-PROD_W){1'b0}}, w_prod});
    w_acc_nxt = w_sub ? (r_acc - w_term) : (r_acc + w_term);
  end

  // Final scaling, flag derivation and saturation of the accumulated sum.
  always_comb begin
    w_acc_rnd = r_acc + RND_ADD;
    w_r       = w_acc_rnd >>> SHIFT;
    w_r_ext   = EXT_W'(unsigned'(w_r));
    w_neg     = r_acc[ACC_W-1];
    w_zero    = (r_acc == '0);
    w_ovf     = !w_neg && !w_zero && (w_r_ext >= OVF_LIM);
    if (w_neg || w_zero) w_sum = '0;
    else if (w_ovf)      w_sum = '1;
    else                 w_sum = w_r_ext[OUT_W-1:0];
  end

  // Operand latch, accumulator, term index and held result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n   <= '0;
      r_acc <= '0;
      r_idx <= '0;
      r_sum <= '0;
      r_vld <= 1'b0;
      r_err <= '0;
    end else begin
      r_vld <= 1'b0;
      if (w_load) begin
        r_n   <= bus.i_n;
        r_acc <= '0;
        r_idx <= '0;
        r_err <= '0;
      end
      if (w_mac) begin
        r_acc <= w_acc_nxt;
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_fin) begin
        r_sum <= w_sum;
        r_err <= {w_ovf, w_zero, w_neg};
        r_vld <= 1'b1;
      end
    end
  end

  assign bus.o_busy = (r_state != IDLE);
  assign bus.o_sum  = r_sum;
  assign bus.o_vld  = r_vld;
  assign bus.o_err  = r_err;

endmodule

// File: tb/tb_alt_cal_wsum.sv
// Bench for alt_cal_wsum: three instances (defaults, ROUND=1, OUT_W=16)
// share one stimulus stream and are checked against an arithmetic model.
module tb_alt_cal_wsum;
  localparam int NT = 3;
  localparam int IW = 25;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [NT*IW-1:0] nvec = '0;

  int n_vec = 0;
  int n_bad = 0;

  longint coef [3] = '{64'd483207710, 64'd5592433, 64'd827155766};
  bit     sub  [3] = '{1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  alt_cal_wsum_if #(.NTERM(3), .IN_W(25), .OUT_W(32)) if_d ();
  alt_cal_wsum_if #(.NTERM(3), .IN_W(25), .OUT_W(32)) if_r ();
  alt_cal_wsum_if #(.NTERM(3), .IN_W(25), .OUT_W(16)) if_o ();

  assign if_d.i_start = start;  assign if_d.i_abort = abort;  assign if_d.i_n = nvec;
  assign if_r.i_start = start;  assign if_r.i_abort = abort;  assign if_r.i_n = nvec;
  assign if_o.i_start = start;  assign if_o.i_abort = abort;  assign if_o.i_n = nvec;

  alt_cal_wsum u_d (.clk(clk), .rst_n(rst_n), .bus(if_d.slave));
  alt_cal_wsum #(.ROUND(1'b1)) u_r (.clk(clk), .rst_n(rst_n), .bus(if_r.slave));
  alt_cal_wsum #(.OUT_W(16)) u_o (.clk(clk), .rst_n(rst_n), .bus(if_o.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed sum of products, then scale/round/saturate.
  task automatic model(input logic [NT*IW-1:0] n, input bit rnd, input int ow,
                       output logic [63:0] s, output logic [63:0] e);
    longint acc;
    longint r;
    longint lim;
    acc = 0;
    for (int k = 0; k < NT; k++) begin
      longint nk;
      nk = longint'(n[k*IW +: IW]);
      if (sub[k]) acc = acc - nk * coef[k];
      else        acc = acc + nk * coef[k];
    end
    lim = longint'(1) << ow;
    if (acc < 0) begin
      s = 0; e = 64'd1;
    end else if (acc == 0) begin
      s = 0; e = 64'd2;
    end else begin
      r = (acc + (rnd ? (longint'(1) << 21) : longint'(0))) >>> 22;
      if (r >= lim) begin s = 64'(lim - 1); e = 64'd4; end
      else          begin s = 64'(r);       e = 64'd0; end
    end
  endtask

  // Apply start for one cycle; returns at the falling edge after the sampling edge.
  task automatic launch(input logic [NT*IW-1:0] n);
    nvec  = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_vld(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!if_d.o_vld && cyc < 20);
    chk("vld_seen", if_d.o_vld, 1'b1);
  endtask

  logic [63:0] last_d;

  task automatic check_res(input string tag, input logic [NT*IW-1:0] n);
    logic [63:0] s;
    logic [63:0] e;
    model(n, 1'b0, 32, s, e);
    chk({tag, "_sum_d"}, if_d.o_sum, s);
    chk({tag, "_err_d"}, if_d.o_err, e);
    last_d = s;
    model(n, 1'b1, 32, s, e);
    chk({tag, "_vld_r"}, if_r.o_vld, 1'b1);
    chk({tag, "_sum_r"}, if_r.o_sum, s);
    chk({tag, "_err_r"}, if_r.o_err, e);
    model(n, 1'b0, 16, s, e);
    chk({tag, "_vld_o"}, if_o.o_vld, 1'b1);
    chk({tag, "_sum_o"}, if_o.o_sum, s);
    chk({tag, "_err_o"}, if_o.o_err, e);
    chk({tag, "_busy_done"}, if_d.o_busy, 1'b0);
  endtask

  function automatic logic [NT*IW-1:0] pack3(input int n2, input int n1, input int n0);
    logic [NT*IW-1:0] v;
    v = {IW'(n2), IW'(n1), IW'(n0)};
    return v;
  endfunction

  initial begin
    int cyc;
    bit seen;
    logic [NT*IW-1:0] va;
    logic [NT*IW-1:0] vb;

    // Reset values
    @(negedge clk);
    chk("rst_busy", if_d.o_busy, 1'b0);
    chk("rst_sum",  if_d.o_sum,  '0);
    chk("rst_vld",  if_d.o_vld,  1'b0);
    chk("rst_err",  if_d.o_err,  '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Main example, latency and busy duration
    launch(pack3(0, 0, 1000));
    chk("ex_busy", if_d.o_busy, 1'b1);
    wait_vld(cyc);
    chk("ex_latency", cyc, 4);
    chk("ex_sum_d_const", if_d.o_sum, 115205);
    chk("ex_sum_r_const", if_r.o_sum, 115206);
    chk("ex_sum_o_const", if_o.o_sum, 65535);
    chk("ex_err_o_const", if_o.o_err, 3'b100);
    check_res("ex", pack3(0, 0, 1000));
    @(negedge clk);
    chk("vld_pulse", if_d.o_vld, 1'b0);

    // Negative and zero sums
    launch(pack3(0, 1, 0));
    wait_vld(cyc);
    chk("neg_err_const", if_d.o_err, 3'b001);
    check_res("neg", pack3(0, 1, 0));
    launch(pack3(0, 0, 0));
    wait_vld(cyc);
    chk("zero_err_const", if_d.o_err, 3'b010);
    check_res("zero", pack3(0, 0, 0));

    // Operand isolation, ignored start while busy, back-to-back restart
    va = pack3(3, 0, 2000000);
    vb = pack3(0, 7, 123456);
    launch(va);
    @(negedge clk);
    nvec  = vb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nvec  = pack3(1, 1, 1);
    wait_vld(cyc);
    chk("iso_latency", cyc, 2);
    check_res("iso", va);
    launch(vb);
    wait_vld(cyc);
    chk("b2b_gap", cyc + 1, 5);
    check_res("b2b", vb);

    // Abort mid-calculation
    launch(pack3(0, 0, 5000));
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", if_d.o_busy, 1'b0);
    chk("abort_vld",  if_d.o_vld,  1'b0);
    chk("abort_sum",  if_d.o_sum,  last_d);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (if_d.o_vld) seen = 1'b1;
    end
    chk("abort_no_vld", seen, 1'b0);
    chk("abort_sum_hold", if_d.o_sum, last_d);

    // Start and abort together in IDLE: start wins
    abort = 1'b1;
    launch(pack3(2, 0, 99999));
    abort = 1'b0;
    chk("stab_busy", if_d.o_busy, 1'b1);
    wait_vld(cyc);
    chk("stab_latency", cyc, 4);
    check_res("stab", pack3(2, 0, 99999));

    // Asynchronous reset mid-operation
    launch(pack3(0, 0, 777));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", if_d.o_busy, 1'b0);
    chk("arst_sum",  if_d.o_sum,  '0);
    chk("arst_err",  if_d.o_err,  '0);
    chk("arst_vld",  if_d.o_vld,  1'b0);
    chk("arst_sum_o", if_o.o_sum, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (if_d.o_vld) seen = 1'b1;
    end
    chk("arst_no_vld", seen, 1'b0);

    // Randomized operands
    for (int t = 0; t < 40; t++) begin
      logic [NT*IW-1:0] v;
      for (int k = 0; k < NT; k++) begin
        case ($urandom_range(0, 3))
          0:       v[k*IW +: IW] = '0;
          1:       v[k*IW +: IW] = IW'($urandom_range(0, 2000));
          default: v[k*IW +: IW] = IW'($urandom);
        endcase
      end
      if ($urandom_range(0, 2) == 0) v[IW +: 2*IW] = '0;
      launch(v);
      wait_vld(cyc);
      chk("rnd_latency", cyc, 4);
      check_res("rnd", v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
